// File: rtl/eth_tx_framer.sv
// eth_tx_framer: Ethernet MAC transmit framer with a byte-wide GMII-style output.
// It generates the preamble and SFD, then the payload. It appends the IEEE 802.3 FCS
// and turns a source underrun into a PHY error symbol. It enforces the inter-packet gap.
// Optional feature: define ETH_TX_PAD_EN to zero-pad payloads shorter than MIN_PAYLOAD.
module eth_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IPG_LEN      = 12,
    parameter int MIN_PAYLOAD  = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] phy_tx_data,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic       frame_done,
    output logic       underrun
);
    // Handshake: a beat transfers on the rising edge where s_valid && s_ready.
    // s_ready is a function of registered state only, never of s_valid. Once
    // s_ready is high in SFD/DATA the source must keep s_valid high until s_last,
    // otherwise the frame is aborted as an underrun.

    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IPG, DRAIN} state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IPG_LAST = 8'(IPG_LEN - 1);

    // The state names what the PHY outputs carry during the current cycle.
    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;      // preamble / FCS / IPG position
    logic        hold, hold_nxt;    // s_ready suppressed: last beat on PHY, or abort symbol
    logic [31:0] crc, crc_nxt;
    logic [7:0]  data_nxt;
    logic        en_nxt, er_nxt, done_nxt, ur_nxt;
    logic        start;
`ifdef ETH_TX_PAD_EN
    localparam logic [15:0] MIN_BYTES = 16'(MIN_PAYLOAD);
    logic [15:0] byte_cnt, byte_cnt_nxt;
`endif

    // Reflected CRC-32 update for one byte, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // FCS byte idx of the complemented CRC, low byte first.
    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] f;
        f = ~c;
        return f[{idx, 3'b000} +: 8];
    endfunction

    assign s_ready = (state == SFD) || (((state == DATA) || (state == DRAIN)) && !hold);

    // Next-state and next-output logic; every PHY output is registered below.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hold_nxt  = 1'b0;
        crc_nxt   = crc;
        data_nxt  = 8'h00;
        en_nxt    = 1'b0;
        er_nxt    = 1'b0;
        done_nxt  = 1'b0;
        ur_nxt    = 1'b0;
        start     = 1'b0;
`ifdef ETH_TX_PAD_EN
        byte_cnt_nxt = byte_cnt;
`endif
        case (state)
            IDLE: start = s_valid;
            PREAMBLE: begin
                en_nxt = 1'b1;
                if (cnt == PRE_LAST) begin
                    state_nxt = SFD;
                    data_nxt  = 8'hD5;
                end else begin
                    cnt_nxt  = cnt + 8'd1;
                    data_nxt = 8'h55;
                end
            end
            SFD, DATA, PAD: begin
                en_nxt = 1'b1;
                if ((state != PAD) && !hold) begin
                    if (s_valid) begin
                        state_nxt = DATA;
                        data_nxt  = s_data;
                        crc_nxt   = crc_byte(crc, s_data);
                        hold_nxt  = s_last;
`ifdef ETH_TX_PAD_EN
                        byte_cnt_nxt = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
`endif
                    end else begin
                        // Source starved the link: emit one error symbol, then drain.
                        state_nxt = DRAIN;
                        er_nxt    = 1'b1;
                        ur_nxt    = 1'b1;
                        hold_nxt  = 1'b1;
                    end
                end else begin
`ifdef ETH_TX_PAD_EN
                    if (byte_cnt < MIN_BYTES) begin
                        state_nxt    = PAD;
                        crc_nxt      = crc_byte(crc, 8'h00);
                        byte_cnt_nxt = byte_cnt + 16'd1;
                    end else
`endif
                    begin
                        state_nxt = FCS;
                        cnt_nxt   = 8'd0;
                        data_nxt  = fcs_byte(crc, 2'd0);
                    end
                end
            end
            FCS: begin
                if (cnt == 8'd3) begin
                    state_nxt = IPG;
                    cnt_nxt   = 8'd0;
                end else begin
                    en_nxt   = 1'b1;
                    cnt_nxt  = cnt + 8'd1;
                    data_nxt = fcs_byte(crc, cnt[1:0] + 2'd1);
                    done_nxt = (cnt == 8'd2);
                end
            end
            IPG: begin
                if (cnt == IPG_LAST) begin
                    if (s_valid) start = 1'b1;
                    else state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (!hold && s_valid && s_last) begin
                    state_nxt = IPG;
                    cnt_nxt   = 8'd0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (start) begin
            state_nxt = PREAMBLE;
            cnt_nxt   = 8'd0;
            en_nxt    = 1'b1;
            data_nxt  = 8'h55;
            crc_nxt   = 32'hFFFFFFFF;
`ifdef ETH_TX_PAD_EN
            byte_cnt_nxt = 16'd0;
`endif
        end
    end

    // State, counters, CRC and registered PHY outputs; async reset cuts any frame short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            hold        <= 1'b0;
            crc         <= 32'hFFFFFFFF;
            phy_tx_data <= 8'h00;
            phy_tx_en   <= 1'b0;
            phy_tx_er   <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
`ifdef ETH_TX_PAD_EN
            byte_cnt    <= 16'd0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            hold        <= hold_nxt;
            crc         <= crc_nxt;
            phy_tx_data <= data_nxt;
            phy_tx_en   <= en_nxt;
            phy_tx_er   <= er_nxt;
            frame_done  <= done_nxt;
            underrun    <= ur_nxt;
`ifdef ETH_TX_PAD_EN
            byte_cnt    <= byte_cnt_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_eth_tx_framer.sv
// tb_eth_tx_framer: directed and randomized frames against a byte-level frame model.
// The model builds each expected PHY byte sequence from the frame rules: preamble,
// SFD, payload, optional pad, and an FCS computed bit-serially over the body.
`timescale 1ns/1ps
module tb_eth_tx_framer;
    localparam int PRE  = 7;
    localparam int IPG  = 12;
    localparam int MINP = 60;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] phy_tx_data;
    logic       phy_tx_en;
    logic       phy_tx_er;
    logic       frame_done;
    logic       underrun;

    eth_tx_framer #(.PREAMBLE_LEN(PRE), .IPG_LEN(IPG), .MIN_PAYLOAD(MINP)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .phy_tx_data(phy_tx_data), .phy_tx_en(phy_tx_en),
        .phy_tx_er(phy_tx_er), .frame_done(frame_done), .underrun(underrun)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Scoreboard entries: {frame_done, phy_tx_er, phy_tx_data} for every enabled PHY cycle.
    logic [9:0] exp_q[$];

    function automatic logic [31:0] ref_fcs(input byte_q_t msg);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFFFFFF;
        foreach (msg[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ msg[i][b];
                r  = (r >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
            end
        end
        return ~r;
    endfunction

    task automatic push_header();
        for (int i = 0; i < PRE; i++) exp_q.push_back({2'b00, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
    endtask

    task automatic expect_frame(input byte_q_t pay);
        byte_q_t     body;
        logic [31:0] f;
        body = pay;
`ifdef ETH_TX_PAD_EN
        while (body.size() < MINP) body.push_back(8'h00);
`endif
        f = ref_fcs(body);
        push_header();
        foreach (body[i]) exp_q.push_back({2'b00, body[i]});
        for (int i = 0; i < 4; i++) exp_q.push_back({(i == 3) ? 1'b1 : 1'b0, 1'b0, f[8*i +: 8]});
    endtask

    // ---------------- monitor ----------------
    bit         mon_on = 1'b0;
    bit         have_prev = 1'b0;
    bit         tight_gap = 1'b0;
    bit         last_end = 1'b0;
    int         gap = 0;
    int         run_len = 0;
    int         last_run = 0;
    int         first_en_cyc = 0;
    logic [9:0] e;

    initial forever begin
        @(negedge clk);
        if (rst || !mon_on) begin
            have_prev = 1'b0;
            run_len   = 0;
            gap       = 0;
        end else if (phy_tx_en) begin
            if (run_len == 0) begin
                if (have_prev) begin
                    if (tight_gap) check("ipg_exact", 32'(gap), 32'(IPG));
                    else check("ipg_min", 32'(gap >= IPG), 32'd1);
                end
                first_en_cyc = cyc;
            end
            run_len++;
            if (exp_q.size() == 0) begin
                check("unexpected_tx", 32'(phy_tx_en), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", 32'({frame_done, phy_tx_er, phy_tx_data}), 32'(e));
                check("underrun_pulse", 32'(underrun), 32'(e[8]));
                last_end = e[9] | e[8];
            end
        end else begin
            check("idle_outputs", 32'({phy_tx_er, frame_done, underrun, phy_tx_data}), 32'd0);
            if (run_len != 0) begin
                check("frame_contiguous", 32'(last_end), 32'd1);
                last_run  = run_len;
                run_len   = 0;
                have_prev = 1'b1;
                gap       = 0;
            end
            if (have_prev) gap++;
        end
    end

    // ---------------- driver tasks (called right after a falling edge) ----------------
    task automatic put_beat(input logic [7:0] d, input logic l);
        int budget;
        budget  = 1000;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("ready_timeout", 32'(s_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t pay, input bit keep_valid);
        expect_frame(pay);
        foreach (pay[i]) put_beat(pay[i], (i == pay.size() - 1) ? 1'b1 : 1'b0);
        if (!keep_valid) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            s_data  = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic send_underrun(input int n_ok, input int n_drain);
        byte_q_t pay;
        for (int i = 0; i < n_ok; i++) pay.push_back(8'($urandom_range(0, 255)));
        push_header();
        foreach (pay[i]) exp_q.push_back({2'b00, pay[i]});
        exp_q.push_back({2'b01, 8'h00});
        foreach (pay[i]) put_beat(pay[i], 1'b0);
        s_valid = 1'b0;
        s_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
        for (int i = 0; i < n_drain; i++)
            put_beat(8'($urandom_range(0, 255)), (i == n_drain - 1) ? 1'b1 : 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 5000;
        while ((exp_q.size() != 0 || phy_tx_en) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (IPG + 2) @(negedge clk);
    endtask

    function automatic byte_q_t rand_payload(input int len);
        byte_q_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        byte_q_t pay;
        int      start_cyc;

        repeat (3) @(negedge clk);
        check("reset_state", 32'({s_ready, phy_tx_en, phy_tx_er, frame_done, underrun, phy_tx_data}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'({s_ready, phy_tx_en}), 32'd0);
        mon_on = 1'b1;

        // Known check vector "123456789".
        pay = {};
        for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
        start_cyc = cyc;
`ifdef ETH_TX_PAD_EN
        send_frame(pay, 1'b0);
`else
        push_header();
        foreach (pay[i]) exp_q.push_back({2'b00, pay[i]});
        exp_q.push_back({2'b00, 8'h26});
        exp_q.push_back({2'b00, 8'h39});
        exp_q.push_back({2'b00, 8'hF4});
        exp_q.push_back({2'b10, 8'hCB});
        foreach (pay[i]) put_beat(pay[i], (i == 8) ? 1'b1 : 1'b0);
        s_valid = 1'b0;
        s_last  = 1'b0;
`endif
        wait_drain();
        check("start_latency", 32'(first_en_cyc - start_cyc), 32'd1);
`ifndef ETH_TX_PAD_EN
        check("vector_en_cycles", 32'(last_run), 32'd21);
`endif

        // Single-byte payload: s_last in the SFD cycle.
        pay = {8'hAB};
        send_frame(pay, 1'b0);
        wait_drain();
`ifdef ETH_TX_PAD_EN
        check("pad_en_cycles", 32'(last_run), 32'(PRE + 1 + MINP + 4));
`else
        check("short_en_cycles", 32'(last_run), 32'(PRE + 1 + 1 + 4));
`endif

        // 64-byte payload: never padded.
        send_frame(rand_payload(64), 1'b0);
        wait_drain();
        check("long_en_cycles", 32'(last_run), 32'(PRE + 1 + 64 + 4));

        // Underrun after 5 accepted bytes, then drain three beats.
        send_underrun(5, 3);
        wait_drain();

        // Back-to-back frames with s_valid held high.
        send_frame(rand_payload(20), 1'b1);
        tight_gap = 1'b1;
        send_frame(rand_payload(3), 1'b1);
        send_frame(rand_payload(70), 1'b0);
        tight_gap = 1'b0;
        wait_drain();

        // Async reset while the third payload byte is on the PHY.
        mon_on = 1'b0;
        pay = rand_payload(10);
        for (int i = 0; i < 3; i++) put_beat(pay[i], 1'b0);
        check("pre_reset_byte", 32'({phy_tx_en, phy_tx_data}), 32'({1'b1, pay[2]}));
        rst = 1'b1;
        #1;
        check("reset_mid_frame", 32'({s_ready, phy_tx_en, phy_tx_er, frame_done, underrun, phy_tx_data}), 32'd0);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("idle_after_mid_reset", 32'({s_ready, phy_tx_en}), 32'd0);
        mon_on = 1'b1;
        send_frame(rand_payload(9), 1'b0);
        wait_drain();

        // Randomized mix of frames and underruns with random idle gaps.
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 4) == 0)
                send_underrun($urandom_range(1, 8), $urandom_range(1, 4));
            else
                send_frame(rand_payload($urandom_range(1, 75)), $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        s_valid = 1'b0;
        wait_drain();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
